multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle CPU variant. It consumes the decoded opcode and function fields (OPECODE/FUNCT) from the instruction decoder and the ALU zero flag, and sequences the shared datapath (one memory, one ALU) across several cycles per instruction. Memory accesses use a req/ready handshake so that wait states are tolerated. An illegal instruction halts the core until reset.

Parameters:
FETCH_PC_INC, 2'b01, alu_src_b select for the constant 4 (PC+4 path)
ENABLE_TRAP, 1, 1: an illegal op/funct enters HALT; 0: it is treated as a NOP and returns to FETCH

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
op  input  OPECODE  decoded opcode from the instruction register
funct  input  FUNCT  decoded R-type function
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access requested
mem_write  output  1  store strobe, valid only when mem_req is high
iord  output  1  0: address = PC; 1: address = ALUOut
ir_write  output  1  latch instruction register
reg_dst  output  1  1: rd; 0: rt
mem_to_reg  output  1  1: write-back from the data register
reg_write  output  1  register file write enable
alu_src_a  output  1  0: PC; 1: register A
alu_src_b  output  2  00: B, 01: 4, 10: sign-extended imm, 11: imm<<2
alu_control  output  3  ALU operation
pc_src  output  2  00: ALU result, 01: ALUOut, 10: jump target
pc_en  output  1  PC write enable (pc_write | branch&zero)
instr_done  output  1  one-cycle pulse when an instruction retires
halted  output  1  sticky illegal-instruction indication

Behaviour:
- State register: Moore outputs decoded from the state, except that memory-state write enables are qualified by mem_ready and pc_en is qualified by zero.
- While reset is high, every output is 0. At the clock edge with reset high, the state becomes FETCH and halted is cleared. A reset mid-instruction discards that instruction with no partial writes.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=FETCH_PC_INC, alu_control=ADD(010), pc_src=00.
  - If mem_ready: ir_write=1, pc_en=1, and the next state is DECODE.
  - Otherwise the FSM holds in FETCH with ir_write=0 and pc_en=0.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by op:
  - LW/SW→MEMADR
  - RTYPE→EXECUTE, or ILLEGAL if funct==INVALID
  - BEQ→BRANCH
  - ADDI→ADDIEX
  - J→JUMP
  - INVALID→ILLEGAL
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1, then FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. When mem_ready: instr_done=1, then FETCH. Otherwise it holds, with mem_write staying high and stable.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct: ADD 010, SUB 110, AND 000, OR 001, SLT 111. Next state is ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_en=zero, instr_done=1, then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD, then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1, then FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1, then FETCH.
- ILLEGAL:
  - ENABLE_TRAP=1: go to HALT.
  - ENABLE_TRAP=0: instr_done=1, go to FETCH.
- HALT: halted=1 and all enables are 0. It is absorbing until reset.
- Cycles per instruction with zero wait states:
  - LW 5
  - SW 4
  - R-type 4
  - ADDI 4
  - BEQ 3
  - J 3
  - Each mem_ready-low cycle in FETCH, MEMRD or MEMWR adds 1.
- mem_ready outside a memory state is ignored.
- Unreachable state encodings recover to FETCH.

Decomposition:
- lib_cpu package additions:
  - CTRL_STATE enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ILLEGAL, HALT)
  - ALU_CTRL enum (ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111)
  - ALU_OP enum (AOP_ADD, AOP_SUB, AOP_FUNCT)
  - SRCB_* and PCSRC_* localparams
- One sub-module, alu_decoder: a combinational mapping ALU_OP × FUNCT → ALU_CTRL, instantiated once. The FSM emits ALU_OP.

Test Plan:
- Reset: hold reset 3 cycles with mem_ready=1 → all outputs 0. First cycle after release: state FETCH, mem_req=1, iord=0.
- LW, mem_ready always 1 → exactly 5 cycles. ir_write and pc_en in cycle 1; reg_write=1 with mem_to_reg=1 and instr_done=1 in cycle 5; the next cycle is FETCH.
- SW with mem_ready low for 2 cycles in MEMWR → mem_write held high for 3 cycles. instr_done pulses once, on the ready cycle. Total 6 cycles.
- BEQ twice, once with zero=1 and once with zero=0 → pc_en=1 with pc_src=01 in cycle 3 when zero=1; pc_en=0 when zero=0. 3 cycles each.
- R-type with funct=SUB → alu_control=110 in EXECUTE, reg_write=1 with reg_dst=1 in ALUWB. Repeat with funct=SLT → 111.
- op=INVALID (ENABLE_TRAP=1) → DECODE→ILLEGAL→HALT; halted=1 with no enables for 20 cycles. Then reset → halted=0 and FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and select encodings for the multicycle CPU control path.
package multicycle_ctrl_pkg;

  // Decoded opcode classes delivered by the instruction decoder
  typedef enum logic [2:0] {
    OP_RTYPE   = 3'd0,
    OP_LW      = 3'd1,
    OP_SW      = 3'd2,
    OP_BEQ     = 3'd3,
    OP_ADDI    = 3'd4,
    OP_J       = 3'd5,
    OP_INVALID = 3'd6
  } OPECODE;

  // Decoded R-type function classes
  typedef enum logic [2:0] {
    FN_ADD     = 3'd0,
    FN_SUB     = 3'd1,
    FN_AND     = 3'd2,
    FN_OR      = 3'd3,
    FN_SLT     = 3'd4,
    FN_INVALID = 3'd5
  } FUNCT;

  // Control FSM states
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
    ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ILLEGAL, HALT
  } CTRL_STATE;

  // ALU operation codes as seen by the datapath
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } ALU_CTRL;

  // Coarse ALU request from the FSM; AOP_FUNCT defers to the function field
  typedef enum logic [1:0] {
    AOP_ADD   = 2'd0,
    AOP_SUB   = 2'd1,
    AOP_FUNCT = 2'd2
  } ALU_OP;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for function codes the ALU can actually execute
  function automatic logic funct_legal(input FUNCT f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps the FSM's coarse ALU request and the R-type function to an ALU opcode.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  ALU_OP   i_alu_op,
  input  FUNCT    i_funct,
  output ALU_CTRL o_alu_ctrl
);

  // Pure lookup; unknown function codes fall back to ADD so the ALU is never undefined
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_alu_op)
      AOP_ADD: o_alu_ctrl = ALU_ADD;
      AOP_SUB: o_alu_ctrl = ALU_SUB;
      AOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_ctrl = ALU_ADD;
          FN_SUB:  o_alu_ctrl = ALU_SUB;
          FN_AND:  o_alu_ctrl = ALU_AND;
          FN_OR:   o_alu_ctrl = ALU_OR;
          FN_SLT:  o_alu_ctrl = ALU_SLT;
          default: o_alu_ctrl = ALU_ADD;
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle CPU: sequences the shared memory/ALU datapath.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [1:0] FETCH_PC_INC = SRCB_FOUR,
  parameter bit         ENABLE_TRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  OPECODE     op,
  input  FUNCT       funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       instr_done,
  output logic       halted
);

  CTRL_STATE r_state;
  ALU_OP     w_alu_op;
  ALU_CTRL   w_alu_ctrl;

  alu_decoder u_alu_decoder (
    .i_alu_op   (w_alu_op),
    .i_funct    (funct),
    .o_alu_ctrl (w_alu_ctrl)
  );

  // State sequencing; memory states stall on mem_ready, HALT is left only through reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:   if (mem_ready) r_state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= MEMADR;
            OP_RTYPE:     r_state <= funct_legal(funct) ? EXECUTE : ILLEGAL;
            OP_BEQ:       r_state <= BRANCH;
            OP_ADDI:      r_state <= ADDIEX;
            OP_J:         r_state <= JUMP;
            default:      r_state <= ILLEGAL;
          endcase
        end
        MEMADR:  r_state <= (op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   if (mem_ready) r_state <= MEMWB;
        MEMWB:   r_state <= FETCH;
        MEMWR:   if (mem_ready) r_state <= FETCH;
        EXECUTE: r_state <= ALUWB;
        ALUWB:   r_state <= FETCH;
        BRANCH:  r_state <= FETCH;
        ADDIEX:  r_state <= ADDIWB;
        ADDIWB:  r_state <= FETCH;
        JUMP:    r_state <= FETCH;
        ILLEGAL: r_state <= ENABLE_TRAP ? HALT : FETCH;
        HALT:    r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Moore decode of the datapath controls; reset forces everything low so a
  // half-finished instruction cannot write anything while reset is held
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    pc_en      = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    w_alu_op   = AOP_ADD;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = FETCH_PC_INC;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        DECODE:  alu_src_b = SRCB_IMM_SH2;
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        EXECUTE: begin
          alu_src_a = 1'b1;
          w_alu_op  = AOP_FUNCT;
        end
        ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          w_alu_op   = AOP_SUB;
          pc_src     = PCSRC_ALUOUT;
          pc_en      = zero;
          instr_done = 1'b1;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_src     = PCSRC_JUMP;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
        ILLEGAL: instr_done = ~ENABLE_TRAP;
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

  // ALU opcode is also blanked during reset so every output reads zero
  assign alu_control = reset ? 3'b000 : w_alu_ctrl;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: each instruction is
// expanded into an expected per-cycle timeline of control outputs.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  OPECODE     op;
  FUNCT       funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, pc_en, instr_done, halted;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;

  typedef struct packed {
    logic       memReq;
    logic       memWrite;
    logic       iord;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       srcA;
    logic [1:0] srcB;
    logic [2:0] aluCtrl;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic       instrDone;
    logic       halted;
  } outs_t;

  typedef struct {
    outs_t v;
    outs_t m;
    logic  rdy;
  } step_t;

  step_t  trace[$];
  int     nChecks = 0;
  int     nErrors = 0;
  OPECODE kinds[6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

  multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .iord        (iord),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .pc_src      (pc_src),
    .pc_en       (pc_en),
    .instr_done  (instr_done),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Gathers the DUT outputs into one comparable word
  function automatic outs_t getOutputs();
    outs_t o;
    o.memReq    = mem_req;
    o.memWrite  = mem_write;
    o.iord      = iord;
    o.irWrite   = ir_write;
    o.regDst    = reg_dst;
    o.memToReg  = mem_to_reg;
    o.regWrite  = reg_write;
    o.srcA      = alu_src_a;
    o.srcB      = alu_src_b;
    o.aluCtrl   = alu_control;
    o.pcSrc     = pc_src;
    o.pcEn      = pc_en;
    o.instrDone = instr_done;
    o.halted    = halted;
    return o;
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [17:0] observed, input logic [17:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // A cycle where all strobes/enables are expected low; mux selects unchecked
  function automatic step_t newStep();
    step_t s;
    s.v = '0;
    s.m = '0;
    s.m.memReq = 1'b1; s.m.memWrite = 1'b1; s.m.irWrite = 1'b1;
    s.m.regWrite = 1'b1; s.m.pcEn = 1'b1; s.m.instrDone = 1'b1; s.m.halted = 1'b1;
    s.rdy = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic step_t aluStep(input step_t si, input logic a, input logic [1:0] b, input logic [2:0] c);
    step_t s = si;
    s.v.srcA = a;    s.m.srcA = 1'b1;
    s.v.srcB = b;    s.m.srcB = 2'b11;
    s.v.aluCtrl = c; s.m.aluCtrl = 3'b111;
    return s;
  endfunction

  function automatic logic [2:0] expAlu(input FUNCT f);
    case (f)
      FN_ADD:  return 3'b010;
      FN_SUB:  return 3'b110;
      FN_AND:  return 3'b000;
      FN_OR:   return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  // Expected timeline of one instruction with the given wait states
  task automatic buildTrace(input OPECODE k, input FUNCT f, input int fw, input int mw, input logic z);
    step_t s;
    trace.delete();
    for (int i = 0; i <= fw; i++) begin
      s = aluStep(newStep(), 1'b0, 2'b01, 3'b010);
      s.v.memReq = 1'b1;
      s.m.iord = 1'b1; s.m.pcSrc = 2'b11;
      s.rdy = (i == fw);
      s.v.irWrite = (i == fw);
      s.v.pcEn = (i == fw);
      trace.push_back(s);
    end
    trace.push_back(aluStep(newStep(), 1'b0, 2'b11, 3'b010));
    if (k == OP_INVALID || k == OP_RTYPE && f == FN_INVALID) begin
      s = newStep(); s.m.halted = 1'b0;
      trace.push_back(s);
      for (int i = 0; i < 20; i++) begin
        s = newStep(); s.v.halted = 1'b1;
        trace.push_back(s);
      end
      return;
    end
    case (k)
      OP_LW, OP_SW: begin
        trace.push_back(aluStep(newStep(), 1'b1, 2'b10, 3'b010));
        for (int i = 0; i <= mw; i++) begin
          s = newStep();
          s.v.memReq = 1'b1; s.v.iord = 1'b1; s.m.iord = 1'b1;
          s.v.memWrite = (k == OP_SW);
          s.v.instrDone = (k == OP_SW) && (i == mw);
          s.rdy = (i == mw);
          trace.push_back(s);
        end
        if (k == OP_LW) begin
          s = newStep();
          s.v.regWrite = 1'b1; s.v.instrDone = 1'b1;
          s.v.memToReg = 1'b1; s.m.memToReg = 1'b1; s.m.regDst = 1'b1;
          trace.push_back(s);
        end
      end
      OP_RTYPE: begin
        trace.push_back(aluStep(newStep(), 1'b1, 2'b00, expAlu(f)));
        s = newStep();
        s.v.regWrite = 1'b1; s.v.instrDone = 1'b1;
        s.v.regDst = 1'b1; s.m.regDst = 1'b1; s.m.memToReg = 1'b1;
        trace.push_back(s);
      end
      OP_BEQ: begin
        s = aluStep(newStep(), 1'b1, 2'b00, 3'b110);
        s.v.pcSrc = 2'b01; s.m.pcSrc = 2'b11;
        s.v.pcEn = z; s.v.instrDone = 1'b1;
        trace.push_back(s);
      end
      OP_ADDI: begin
        trace.push_back(aluStep(newStep(), 1'b1, 2'b10, 3'b010));
        s = newStep();
        s.v.regWrite = 1'b1; s.v.instrDone = 1'b1;
        s.m.regDst = 1'b1; s.m.memToReg = 1'b1;
        trace.push_back(s);
      end
      default: begin
        s = newStep();
        s.v.pcSrc = 2'b10; s.m.pcSrc = 2'b11;
        s.v.pcEn = 1'b1; s.v.instrDone = 1'b1;
        trace.push_back(s);
      end
    endcase
  endtask

  // Drives one instruction (optionally cut short) and checks every cycle
  task automatic applyStimulus(input string name, input OPECODE k, input FUNCT f,
                               input int fw, input int mw, input logic z, input int limit);
    buildTrace(k, f, fw, mw, z);
    op = k; funct = f; zero = z;
    for (int i = 0; i < trace.size() && i < limit; i++) begin
      mem_ready = trace[i].rdy;
      @(negedge clk);
      checkOutput($sformatf("%s c%0d", name, i + 1), getOutputs() & trace[i].m, trace[i].v & trace[i].m);
      @(posedge clk); #1;
    end
  endtask

  // Holds reset and expects every output at zero
  task automatic applyReset(input int n);
    reset = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("reset", getOutputs(), '0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    OPECODE k;
    reset = 1'b1; op = OP_RTYPE; funct = FN_ADD; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    applyReset(3);

    applyStimulus("lw",      OP_LW,     FN_ADD, 0, 0, 1'b0, 100);
    applyStimulus("sw_wait", OP_SW,     FN_ADD, 0, 2, 1'b1, 100);
    applyStimulus("beq_z1",  OP_BEQ,    FN_ADD, 0, 0, 1'b1, 100);
    applyStimulus("beq_z0",  OP_BEQ,    FN_ADD, 0, 0, 1'b0, 100);
    applyStimulus("r_sub",   OP_RTYPE,  FN_SUB, 0, 0, 1'b0, 100);
    applyStimulus("r_slt",   OP_RTYPE,  FN_SLT, 0, 0, 1'b1, 100);
    applyStimulus("addi",    OP_ADDI,   FN_OR,  1, 0, 1'b0, 100);
    applyStimulus("j",       OP_J,      FN_AND, 2, 0, 1'b1, 100);

    // Reset during a stalled load read must abandon it
    applyStimulus("lw_cut",  OP_LW,     FN_ADD, 0, 3, 1'b0, 4);
    applyReset(2);

    for (int n = 0; n < 40; n++) begin
      k = kinds[$urandom_range(0, 5)];
      applyStimulus($sformatf("rnd%0d", n), k, FUNCT'($urandom_range(0, 4)),
                    $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 100);
    end

    applyStimulus("invalid_op", OP_INVALID, FN_ADD, 0, 0, 1'b0, 100);
    applyReset(2);
    applyStimulus("after_halt", OP_BEQ,     FN_ADD, 0, 0, 1'b1, 100);
    applyStimulus("bad_funct",  OP_RTYPE,   FN_INVALID, 1, 0, 1'b0, 100);
    applyReset(1);
    applyStimulus("final_lw",   OP_LW,      FN_ADD, 0, 1, 1'b0, 100);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
